i2c_master: RTL and testbench

Single-byte I2C bus master: on a `start` pulse it generates START, sends a 7-bit address plus R/W bit, transfers one data byte in either direction, checks ACKs and generates STOP. It is the initiator counterpart to the team's I2C slave and sits between a register/CPU-side request port and the open-drain SCL/SDA pads. It drives the bus only as "pull low or release", and it is the only master on the bus.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_clk_gen.sv | 50 +++++
 rtl/i2c_master.sv | 177 +++++++++++++++++
 tb/tb_i2c_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master and its quarter-phase clock generator.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_MACK,
        ST_STOP
    } i2c_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int unsigned CLK_DIV_DEFAULT = 125;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-bit timebase: CLK_DIV prescaler plus 2-bit quarter counter.
// Cleared while the master is idle; hold pins the prescaler at 0 (SCL stretching).
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       hold,
    output logic       q_tick,
    output logic [1:0] quarter
);

    localparam logic [11:0] CNT_MAX = 12'(CLK_DIV - 1);

    logic [11:0] cnt_q, cnt_d;
    logic [1:0]  quarter_q, quarter_d;

    assign q_tick  = !clr && !hold && (cnt_q == CNT_MAX);
    assign quarter = quarter_q;

    always_comb begin
        cnt_d     = cnt_q;
        quarter_d = quarter_q;
        if (clr) begin
            cnt_d     = '0;
            quarter_d = Q0;
        end else if (hold) begin
            cnt_d = '0;
        end else if (q_tick) begin
            cnt_d     = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quarter_q <= Q0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte, ACK checks, STOP.
// Optional SCL stretching support (adds scl_in) when I2C_MASTER_CLK_STRETCH_EN is defined.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] slv_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl,
    input  logic       sda_in,
    output logic       sda_out
`ifdef I2C_MASTER_CLK_STRETCH_EN
    ,
    input  logic       scl_in
`endif
);

    localparam logic [2:0] LAST_BIT = 3'd7;

    i2c_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rw_q, rw_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;

    logic       q_tick;
    logic [1:0] quarter;
    logic       stretch_hold;
    logic       bit_end;
    logic       sample_pt;
    logic       scl_hi;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    assign stretch_hold = (quarter == Q2) && !scl_in;
`else
    assign stretch_hold = 1'b0;
`endif

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == ST_IDLE),
        .hold    (stretch_hold),
        .q_tick  (q_tick),
        .quarter (quarter)
    );

    assign bit_end   = q_tick && (quarter == Q3);
    assign sample_pt = q_tick && (quarter == Q2);
    assign scl_hi    = quarter[1];

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        scl       = 1'b1;
        sda_out   = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_START;
                    shift_d   = {slv_addr, rw};
                    rw_d      = rw;
                    wdata_d   = wdata;
                    bit_cnt_d = '0;
                    ack_err_d = 1'b0;
                end
            end
            ST_START: begin
                sda_out = ~quarter[1];
                if (bit_end) state_d = ST_ADDR;
            end
            ST_ADDR, ST_WRITE: begin
                scl     = scl_hi;
                sda_out = shift_q[7];
                if (bit_end) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT)
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
                end
            end
            ST_ADDR_ACK: begin
                scl = scl_hi;
                if (sample_pt && (sda_in == I2C_NACK)) ack_err_d = 1'b1;
                // ack_err_q already holds this bit's sample by the q3 decision point
                if (bit_end) begin
                    if (ack_err_q) begin
                        state_d = ST_STOP;
                    end else if (rw_q) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                        shift_d = wdata_q;
                    end
                end
            end
            ST_WRITE_ACK: begin
                scl = scl_hi;
                if (sample_pt && (sda_in == I2C_NACK)) ack_err_d = 1'b1;
                if (bit_end) state_d = ST_STOP;
            end
            ST_READ: begin
                scl = scl_hi;
                if (sample_pt) rx_d = {rx_q[6:0], sda_in};
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = ST_MACK;
                end
            end
            ST_MACK: begin
                scl     = scl_hi;
                sda_out = I2C_NACK;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                scl     = scl_hi;
                sda_out = (quarter == Q3);
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (rw_q && !ack_err_q) rdata_d = rx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            rx_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bit_cnt_q <= '0;
            rw_q      <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: table of transactions, bus-level responder/monitor, scoreboard queue.
// Exercises the stretching path only when I2C_MASTER_CLK_STRETCH_EN is defined.
module tb_i2c_master;

    localparam int unsigned D = 4;
    localparam int FULL_LAT = 80 * D + 1;
    localparam int NACK_LAT = 44 * D + 1;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       ack_a;
        logic       ack_d;
        logic [7:0] rd;
        logic [7:0] e_addr;
        logic       full;
        logic [7:0] e_b2;
        logic       e_b17;
        logic       e_err;
        logic       chk_rd;
        logic [7:0] e_rd;
        int         lat;
    } vec_t;

    typedef struct {
        logic [31:0] cap;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] slv_addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ack_err;
    logic [7:0] rdata;
    logic       scl, sda_in, sda_out;
    logic       slave_sda = 1'b1;

    assign sda_in = sda_out & slave_sda;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    logic stretch_n = 1'b1;
    logic scl_in;
    assign scl_in = scl & stretch_n;
`endif

    i2c_master #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rw       (rw),
        .slv_addr (slv_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .rdata    (rdata),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_out  (sda_out)
`ifdef I2C_MASTER_CLK_STRETCH_EN
        ,
        .scl_in   (scl_in)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int t_start = 0;
    vec_t   exp_q[$];
    frame_t frame_q[$];

    logic       cfg_rw = 1'b0;
    logic       cfg_ack_a = 1'b1;
    logic       cfg_ack_d = 1'b1;
    logic [7:0] cfg_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt++;

    // Bus responder/monitor: decodes START/STOP, captures a bit on each SCL rise,
    // and changes its own SDA drive only while SCL is low.
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        in_frame = 1'b0;
    logic [31:0] cap = '0;
    int          bit_idx = 0;

    always @(negedge clk) begin
        logic cur_sda;
        cur_sda = sda_in;
        if (!rst_n) begin
            slave_sda = 1'b1;
            in_frame  = 1'b0;
            bit_idx   = 0;
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
        end else begin
            if (prev_scl && scl && prev_sda && !cur_sda) begin
                in_frame = 1'b1;
                bit_idx  = 0;
                cap      = '0;
            end else if (prev_scl && scl && !prev_sda && cur_sda && in_frame) begin
                frame_q.push_back('{cap, bit_idx});
                in_frame = 1'b0;
            end else if (!prev_scl && scl && in_frame) begin
                cap = {cap[30:0], cur_sda};
                bit_idx++;
            end else if (prev_scl && !scl && in_frame) begin
                if (bit_idx == 8)
                    slave_sda = ~cfg_ack_a;
                else if (cfg_rw && cfg_ack_a && bit_idx >= 9 && bit_idx <= 16)
                    slave_sda = cfg_rd[16 - bit_idx];
                else if (!cfg_rw && cfg_ack_a && bit_idx == 17)
                    slave_sda = ~cfg_ack_d;
                else
                    slave_sda = 1'b1;
            end
            prev_scl = scl;
            prev_sda = cur_sda;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input vec_t v, input bit push);
        @(negedge clk);
        slv_addr  = v.addr;
        rw        = v.rw;
        wdata     = v.wdata;
        cfg_rw    = v.rw;
        cfg_ack_a = v.ack_a;
        cfg_ack_d = v.ack_d;
        cfg_rd    = v.rd;
        start     = 1'b1;
        t_start   = cyc;
        if (push) exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_txn(input string tag, input int extra);
        int     lat;
        bit     ok;
        vec_t   e;
        frame_t f;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 200 * D + extra; i++) begin
            if (done) begin
                ok  = 1'b1;
                lat = cyc - t_start;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, ok, 1'b1);
        check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1'b1);
        if (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_latency"}, lat, e.lat + extra);
            check({tag, "_busy_at_done"}, busy, 1'b0);
            check({tag, "_ack_err"}, ack_err, e.e_err);
            if (e.chk_rd) check({tag, "_rdata"}, rdata, e.e_rd);
            check({tag, "_one_frame"}, frame_q.size(), 1);
            if (frame_q.size() > 0) begin
                f = frame_q.pop_front();
                check({tag, "_nbits"}, f.n, e.full ? 19 : 10);
                check({tag, "_addr_byte"}, (f.cap >> (f.n - 8)) & 32'hFF, e.e_addr);
                if (e.full) begin
                    check({tag, "_data_byte"}, (f.cap >> 2) & 32'hFF, e.e_b2);
                    check({tag, "_bit17"}, (f.cap >> 1) & 32'h1, e.e_b17);
                end
                $display("txn %s addr=%02h rw=%0d bits=%0d lat=%0d ack_err=%0d rdata=%02h",
                         tag, e.addr, e.rw, f.n, lat, ack_err, rdata);
            end
            repeat (3) @(negedge clk);
            check({tag, "_ack_err_held"}, ack_err, e.e_err);
        end
        frame_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        #(600000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        vecs[0] = '{7'h51, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 8'hA2, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, FULL_LAT};
        vecs[1] = '{7'h51, 1'b1, 8'h00, 1'b1, 1'b1, 8'hCA, 8'hA3, 1'b1, 8'hCA, 1'b1, 1'b0, 1'b1, 8'hCA, FULL_LAT};
        vecs[2] = '{7'h22, 1'b0, 8'h55, 1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, NACK_LAT};
        vecs[3] = '{7'h51, 1'b0, 8'h96, 1'b1, 1'b0, 8'h00, 8'hA2, 1'b1, 8'h96, 1'b1, 1'b1, 1'b0, 8'h00, FULL_LAT};
        vecs[4] = '{7'h51, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 8'hA2, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, FULL_LAT};
        vecs[5] = '{7'h2D, 1'b1, 8'h00, 1'b1, 1'b1, 8'h35, 8'h5B, 1'b1, 8'h35, 1'b1, 1'b0, 1'b1, 8'h35, FULL_LAT};
        vecs[6] = '{7'h22, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'h45, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, NACK_LAT};

        #1;
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i], 1'b1);
            finish_txn($sformatf("vec%0d", i), 0);
            repeat (4) @(negedge clk);
        end

        // start pulsed mid-ADDR must be ignored
        begin
            vec_t v;
            v = vecs[0];
            v.wdata = 8'hA5;
            v.e_b2  = 8'hA5;
            dc0 = done_cnt;
            launch(v, 1'b1);
            repeat (12 * D) @(negedge clk);
            slv_addr = 7'h10;
            wdata    = 8'hFF;
            rw       = 1'b1;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            finish_txn("ignore_start", 0);
            repeat (40) @(negedge clk);
            check("ignore_start_done_count", done_cnt - dc0, 1);
            check("ignore_start_idle", busy, 1'b0);
        end

        // asynchronous reset in the middle of the data byte
        launch(vecs[0], 1'b0);
        repeat (13 * 4 * D) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_scl", scl, 1'b1);
        check("midrst_sda", sda_out, 1'b1);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frame_q.delete();
        repeat (2) @(negedge clk);
        launch(vecs[4], 1'b1);
        finish_txn("after_reset", 0);

`ifdef I2C_MASTER_CLK_STRETCH_EN
        begin
            logic ps;
            bit   seen;
            launch(vecs[0], 1'b1);
            ps   = scl;
            seen = 1'b0;
            for (int i = 0; i < 20 * D; i++) begin
                @(negedge clk);
                if (!ps && scl) begin
                    seen = 1'b1;
                    break;
                end
                ps = scl;
            end
            check("stretch_scl_rise_seen", seen, 1'b1);
            stretch_n = 1'b0;
            repeat (300) @(negedge clk);
            stretch_n = 1'b1;
            finish_txn("stretch", 300);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
